// File: rtl/data_sync_rx.sv
// Destination-side receiver for a four-phase bus handshake: synchronises BUS_EN,
// captures UNSYNC_BUS once per enable high phase, and returns a level ACK.
module data_sync_rx #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_EN,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 EN_PULSE,
  output logic                 ACK
);

  typedef enum logic {IDLE = 1'b0, ACKING = 1'b1} state_t;

  logic [NUM_STAGES-1:0] sync_q;
  logic                  sync_en;
  state_t                state_q, state_d;
  logic                  capture;

  // Shift register synchroniser; stage 0 is the only flop seeing the async input.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '0;
    else      sync_q <= {sync_q[NUM_STAGES-2:0], BUS_EN};
  end

  assign sync_en = sync_q[NUM_STAGES-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (sync_en) begin
        state_d = ACKING;
        capture = 1'b1;
      end
      ACKING: if (!sync_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ACK mirrors the next state so it rises on capture and falls on the return to IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SYNC_BUS <= '0;
      EN_PULSE <= 1'b0;
      ACK      <= 1'b0;
    end else begin
      if (capture) SYNC_BUS <= UNSYNC_BUS;
      EN_PULSE <= capture;
      ACK      <= (state_d == ACKING);
    end
  end

endmodule

// File: tb/tb_data_sync_rx.sv
// Directed bench for data_sync_rx: latency, single-pulse capture, handshakes,
// async reset, and a narrow N=3/W=1 instance fed a short async enable.
module tb_data_sync_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] bus = '0;
  logic       en  = 1'b0;
  logic [7:0] sbus;
  logic       pulse, ack;

  logic       bus3 = 1'b0;
  logic       en3  = 1'b0;
  logic       sbus3;
  logic       pulse3, ack3;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  data_sync_rx #(.NUM_STAGES(2), .BUS_WIDTH(8)) u_dut (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(bus), .BUS_EN(en),
    .SYNC_BUS(sbus), .EN_PULSE(pulse), .ACK(ack)
  );

  data_sync_rx #(.NUM_STAGES(3), .BUS_WIDTH(1)) u_dut3 (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(bus3), .BUS_EN(en3),
    .SYNC_BUS(sbus3), .EN_PULSE(pulse3), .ACK(ack3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One protocol-obeying transfer; counts pulses and records the captured value.
  task automatic handshake(input logic [7:0] d, output int np, output logic [7:0] cap,
                           output bit timeout);
    int n;
    np = 0; cap = '0; timeout = 0;
    bus = d; en = 1'b1;
    n = 0;
    do begin
      negs(1); n++;
      if (pulse) begin np++; cap = sbus; end
    end while (!ack && n < 50);
    if (!ack) timeout = 1;
    en = 1'b0;
    n = 0;
    do begin
      negs(1); n++;
      if (pulse) begin np++; cap = sbus; end
    end while (ack && n < 50);
    if (ack) timeout = 1;
  endtask

  initial begin
    int np;
    logic [7:0] cap;
    bit to;
    logic [7:0] vals [3] = '{8'h01, 8'h02, 8'hFF};

    // 1: reset and idle
    negs(3);
    chk("rst_sbus", 32'(sbus), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    RST = 1'b1;
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
        negs(1);
        if (sbus !== 8'h00 || pulse !== 1'b0 || ack !== 1'b0) bad++;
      end
      chk("idle_10cyc", 32'(bad), 32'h0);
    end

    // 2: latency of capture and ACK fall
    bus = 8'hA5; en = 1'b1;
    negs(2);
    chk("t2_k1_pulse", 32'(pulse), 32'h0);
    chk("t2_k1_ack", 32'(ack), 32'h0);
    negs(1);
    chk("t2_k2_pulse", 32'(pulse), 32'h1);
    chk("t2_k2_ack", 32'(ack), 32'h1);
    chk("t2_k2_sbus", 32'(sbus), 32'hA5);
    negs(1);
    chk("t2_k3_pulse", 32'(pulse), 32'h0);
    chk("t2_k3_ack", 32'(ack), 32'h1);
    en = 1'b0;
    negs(2);
    chk("t2_fall_k1_ack", 32'(ack), 32'h1);
    negs(1);
    chk("t2_fall_k2_ack", 32'(ack), 32'h0);
    chk("t2_hold_sbus", 32'(sbus), 32'hA5);
    negs(2);

    // 3: long high phase, bus toggling after capture
    bus = 8'h3C; en = 1'b1;
    np = 0;
    for (int i = 0; i < 20; i++) begin
      negs(1);
      if (pulse) np++;
      if (i >= 3) bus = (bus == 8'h3C) ? 8'hC3 : 8'h3C;
    end
    chk("t3_pulses", 32'(np), 32'h1);
    chk("t3_sbus", 32'(sbus), 32'h3C);
    chk("t3_ack_high", 32'(ack), 32'h1);
    en = 1'b0;
    negs(4);
    chk("t3_ack_low", 32'(ack), 32'h0);

    // 4: three back-to-back handshakes
    for (int i = 0; i < 3; i++) begin
      handshake(vals[i], np, cap, to);
      chk($sformatf("t4_timeout%0d", i), 32'(to), 32'h0);
      chk($sformatf("t4_pulses%0d", i), 32'(np), 32'h1);
      chk($sformatf("t4_val%0d", i), 32'(cap), 32'(vals[i]));
    end

    // 5: async reset mid-handshake, release with enable still high
    bus = 8'h77; en = 1'b1;
    negs(4);
    chk("t5_pre_ack", 32'(ack), 32'h1);
    #2;
    RST = 1'b0;
    bus = 8'h5A;
    #1;
    chk("t5_async_sbus", 32'(sbus), 32'h0);
    chk("t5_async_ack", 32'(ack), 32'h0);
    chk("t5_async_pulse", 32'(pulse), 32'h0);
    negs(2);
    RST = 1'b1;
    np = 0; cap = '0;
    begin
      int first = -1;
      for (int i = 0; i < 12; i++) begin
        negs(1);
        if (pulse) begin np++; cap = sbus; if (first < 0) first = i; end
      end
      chk("t5_pulses", 32'(np), 32'h1);
      chk("t5_val", 32'(cap), 32'h5A);
      chk("t5_early", 32'(first >= 1 && first <= 3), 32'h1);
    end
    en = 1'b0;
    negs(4);
    chk("t5_ack_low", 32'(ack), 32'h0);

    // 6: N=3, W=1, one-cycle enable placed away from the clock edge
    bus3 = 1'b1;
    @(negedge CLK);
    #2 en3 = 1'b1;
    #10 en3 = 1'b0;
    np = 0;
    for (int i = 0; i < 15; i++) begin
      negs(1);
      if (pulse3) np++;
    end
    chk("t6_pulses", 32'(np), 32'h1);
    chk("t6_sbus", 32'(sbus3), 32'h1);
    chk("t6_ack_low", 32'(ack3), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
